mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Parametrised successor to the fixed MEM/WB latch. It is a handshaked memory-to-writeback pipeline stage with an optional skid buffer.
- On capture, it formats load data (byte/half/word extraction by address offset, with sign or zero extension) and selects the writeback source.
- It presents registered writeback and forwarding data to the register file and hazard unit, and tracks halt retirement.

Parameters:
XLEN, 32, datapath width (32 or 64; word loads always read the low 32 bits of dload, then extend)
REG_BITS, 5, register index width
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, in_ready = out_ready | ~out_valid

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all held entries
in_valid  in  1  MEM stage has an entry
in_ready  out  1  stage accepts an entry
in_pc  in  XLEN  instruction PC
in_halt  in  1  halt instruction
in_rd  in  REG_BITS  destination register
in_reg_wen  in  1  register write request
in_wr_src  in  2  0 alu, 1 memory, 2 pc+4, 3 reserved
in_mem_size  in  2  0 byte, 1 half, 2 word, 3 reserved
in_mem_signed  in  1  sign-extend load
in_alu_out  in  XLEN  ALU result / load address
in_dload  in  XLEN  raw memory read word
out_valid  out  1  writeback entry valid
out_ready  in  1  writeback consumer accepts
wb_pc  out  XLEN  PC of head entry
wb_rd  out  REG_BITS  destination
wb_wen  out  1  write enable (in_reg_wen and rd != 0, gated by out_valid)
wb_data  out  XLEN  formatted writeback value
wb_misalign  out  1  load offset illegal for size
fwd_valid  out  1  head entry writes a register (out_valid & wb_wen)
fwd_rd  out  REG_BITS  equals wb_rd
fwd_data  out  XLEN  equals wb_data
halted  out  1  sticky: halt entry retired

Behaviour:
- Reset (nRST low, async): both entries invalid, halted=0, all data outputs 0, in_ready=1 once nRST deasserts.
- Capture: in_valid & in_ready at a CLK edge. Formatting happens before the register, so outputs are valid the cycle after capture (latency 1).
- Load formatting, with off = in_alu_out[1:0]:
  - Byte: selects bits [8*off+7 : 8*off].
  - Half: selects the half indexed by off[1]; off[0]=1 sets misalign and uses off[0] as 0.
  - Word (and size 3): uses dload[31:0]; off != 0 sets misalign.
  - Extension: sign if in_mem_signed, else zero, to XLEN.
- Source select: src 0 gives alu_out; 1 gives the formatted load; 2 gives in_pc+4 (mod 2^XLEN); 3 gives 0. misalign is only flagged when src=1.
- Handshake: entry retires on out_valid & out_ready. Outputs are stable while out_valid & ~out_ready.
- SKID_EN=1:
  - in_ready = ~skid_valid (registered).
  - Capture while the head is stalled goes to the skid entry. When the head retires, skid moves to head in the same edge.
  - Capture while the head is retiring with skid empty goes straight to head.
  - Order is strictly FIFO.
- SKID_EN=0: single head entry; capture allowed when the head is empty or retiring in the same cycle.
- Flush: both entries invalid next edge; flush overrides simultaneous capture and retirement. An entry retiring in the flush cycle is still considered retired for halt purposes.
- Halt: halted sets on retirement of an entry with halt=1. Once halted is set, in_ready=0 and halted holds until nRST; flush does not clear it.
- Reset mid-operation: all entries are lost, with no partial writeback.

Decomposition:
- Shared package (common_types_pkg):
  - wb_src_t enum (ALU, MEM, PC4)
  - mem_size_t enum (BYTE, HALF, WORD)
  - mem_wb_entry_t struct (pc, halt, rd, wen, data, misalign)
- Sub-module: load_formatter (combinational: dload, offset, size, signed → data, misalign). It is reused by later load paths.
- Stage core with skid control lives in mem_wb_stage.

Test Plan:
- Byte load, dload=0x80FF7F01, alu_out low bits=2, signed, src=1 → wb_data=0xFFFFFFFF; unsigned → 0x000000FF. Offset 1 signed → 0x0000007F.
- Half load, off=1, src=1 → wb_misalign=1, data from low half 0x7F01 (zero-extended 0x00007F01). src=2 with pc=0xFFFFFFFC → wb_data=0x00000000.
- SKID_EN=1:
  - out_ready=0, push A,B → in_ready drops after B; A held stable.
  - out_ready=1 → A then B on consecutive cycles, no loss or duplication.
- Flush asserted with in_valid=1 and a held entry → next cycle out_valid=0, incoming entry dropped, in_ready=1.
- Retire entry with halt=1 → halted=1 next cycle; further in_valid ignored; flush leaves halted=1; nRST low clears it asynchronously.
- rd=0 with reg_wen=1 → wb_wen=0, fwd_valid=0 while out_valid=1.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the MEM/WB boundary.
// Entry fields are sized for the widest datapath in use.
package common_types_pkg;

  localparam int XLEN_MAX = 64;
  localparam int REG_MAX  = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic                halt;
    logic [REG_MAX-1:0]  rd;
    logic                wen;
    logic [XLEN_MAX-1:0] data;
    logic                misalign;
  } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB handshake bundle plus writeback/forwarding outputs.
// slave is the stage side, master the MEM/WB environment.
interface mem_wb_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) ();

  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic                in_halt;
  logic [REG_BITS-1:0] in_rd;
  logic                in_reg_wen;
  logic [1:0]          in_wr_src;
  logic [1:0]          in_mem_size;
  logic                in_mem_signed;
  logic [XLEN-1:0]     in_alu_out;
  logic [XLEN-1:0]     in_dload;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     wb_pc;
  logic [REG_BITS-1:0] wb_rd;
  logic                wb_wen;
  logic [XLEN-1:0]     wb_data;
  logic                wb_misalign;
  logic                fwd_valid;
  logic [REG_BITS-1:0] fwd_rd;
  logic [XLEN-1:0]     fwd_data;
  logic                halted;

  modport slave (
    input  in_valid, in_pc, in_halt, in_rd,
    input  in_reg_wen, in_wr_src, in_mem_size,
    input  in_mem_signed, in_alu_out, in_dload,
    input  out_ready,
    output in_ready, out_valid, wb_pc, wb_rd,
    output wb_wen, wb_data, wb_misalign,
    output fwd_valid, fwd_rd, fwd_data, halted
  );

  modport master (
    output in_valid, in_pc, in_halt, in_rd,
    output in_reg_wen, in_wr_src, in_mem_size,
    output in_mem_signed, in_alu_out, in_dload,
    output out_ready,
    input  in_ready, out_valid, wb_pc, wb_rd,
    input  wb_wen, wb_data, wb_misalign,
    input  fwd_valid, fwd_rd, fwd_data, halted
  );

endinterface

// File: rtl/load_formatter.sv
// Load data extraction and extension by size/offset.
// Word loads always take the low 32 bits of the raw word.
module load_formatter
  import common_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_dload,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_raw;

  always_comb begin
    w_byte     = i_dload[{i_off, 3'b000} +: 8];
    w_half     = i_off[1] ? i_dload[31:16]
                          : i_dload[15:0];
    w_raw      = i_dload[31:0];
    o_misalign = 1'b0;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        w_raw = {{24{i_signed & w_byte[7]}}, w_byte};
      (i_size == SZ_HALF): begin
        w_raw = {{16{i_signed & w_half[15]}}, w_half};
        o_misalign = i_off[0];
      end
      default:
        o_misalign = |i_off;
    endcase
    o_data = i_signed ? XLEN'($signed(w_raw))
                      : XLEN'(w_raw);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: formats on capture, holds a head entry
// and an optional skid entry, tracks halt retirement.
module mem_wb_stage
  import common_types_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int SKID_EN  = 1
) (
  input logic           CLK,
  input logic           nRST,
  input logic           flush,
  mem_wb_stage_if.slave bus
);

  logic [XLEN-1:0] w_fmt_data;
  logic            w_fmt_mis;
  logic [XLEN-1:0] w_data;
  mem_wb_entry_t   w_new, w_head_nx, w_skid_nx;
  mem_wb_entry_t   r_head, r_skid;
  logic            r_hv, r_sv, r_halted;
  logic            w_hv_nx, w_sv_nx, w_halted_nx;
  logic            w_in_ready, w_cap, w_ret;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .i_dload   (bus.in_dload),
    .i_off     (bus.in_alu_out[1:0]),
    .i_size    (bus.in_mem_size),
    .i_signed  (bus.in_mem_signed),
    .o_data    (w_fmt_data),
    .o_misalign(w_fmt_mis)
  );

  always_comb begin
    w_data = '0;
    unique case (1'b1)
      (bus.in_wr_src == WB_ALU): w_data = bus.in_alu_out;
      (bus.in_wr_src == WB_MEM): w_data = w_fmt_data;
      (bus.in_wr_src == WB_PC4): w_data = bus.in_pc + XLEN'(4);
      default:                   w_data = '0;
    endcase
    w_new                  = '0;
    w_new.pc[XLEN-1:0]     = bus.in_pc;
    w_new.halt             = bus.in_halt;
    w_new.rd[REG_BITS-1:0] = bus.in_rd;
    w_new.wen              = bus.in_reg_wen & (|bus.in_rd);
    w_new.data[XLEN-1:0]   = w_data;
    w_new.misalign         = (bus.in_wr_src == WB_MEM)
                           & w_fmt_mis;
  end

  // Skid mode: ready depends only on flops, so it never
  // combinationally follows out_ready.
  if (SKID_EN != 0) begin : g_skid
    assign w_in_ready = ~r_sv & ~r_halted;
  end else begin : g_single
    assign w_in_ready = (bus.out_ready | ~r_hv) & ~r_halted;
  end

  assign w_cap = bus.in_valid & w_in_ready;
  assign w_ret = r_hv & bus.out_ready;
  assign w_halted_nx = r_halted | (w_ret & r_head.halt);

  always_comb begin
    w_head_nx = r_head;
    w_skid_nx = r_skid;
    w_hv_nx   = r_hv;
    w_sv_nx   = r_sv;
    if (flush) begin
      w_hv_nx = 1'b0;
      w_sv_nx = 1'b0;
    end else if (!r_hv || w_ret) begin
      if (r_sv) begin
        w_head_nx = r_skid;
        w_sv_nx   = 1'b0;
      end else if (w_cap) begin
        w_head_nx = w_new;
        w_hv_nx   = 1'b1;
      end else begin
        w_hv_nx = 1'b0;
      end
    end else if (w_cap) begin
      w_skid_nx = w_new;
      w_sv_nx   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_hv     <= 1'b0;
      r_sv     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_head   <= w_head_nx;
      r_skid   <= w_skid_nx;
      r_hv     <= w_hv_nx;
      r_sv     <= w_sv_nx;
      r_halted <= w_halted_nx;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_hv;
  assign bus.wb_pc       = r_head.pc[XLEN-1:0];
  assign bus.wb_rd       = r_head.rd[REG_BITS-1:0];
  assign bus.wb_wen      = r_hv & r_head.wen;
  assign bus.wb_data     = r_head.data[XLEN-1:0];
  assign bus.wb_misalign = r_head.misalign;
  assign bus.fwd_valid   = r_hv & r_head.wen;
  assign bus.fwd_rd      = r_head.rd[REG_BITS-1:0];
  assign bus.fwd_data    = r_head.data[XLEN-1:0];
  assign bus.halted      = r_halted;

  if (XLEN < XLEN_MAX) begin : g_xpad
    logic w_unused_x;
    assign w_unused_x = ^{r_head.pc[XLEN_MAX-1:XLEN],
                          r_head.data[XLEN_MAX-1:XLEN]};
  end
  if (REG_BITS < REG_MAX) begin : g_rpad
    logic w_unused_r;
    assign w_unused_r = ^r_head.rd[REG_MAX-1:REG_BITS];
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: FIFO reference model with
// per-cycle compare, plus directed literal checks.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32), .REG_BITS(5)) bus ();

  mem_wb_stage #(
    .XLEN(32), .REG_BITS(5), .SKID_EN(1)
  ) dut (
    .CLK  (clk),
    .nRST (nRST),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dload;
    logic        halt;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  src;
    logic [1:0]  size;
    logic        sgn;
  } txn_t;

  int n_pass = 0;
  int n_total = 0;
  txn_t q[$];
  bit m_halted = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] exp_data(txn_t t);
    logic [31:0] v;
    int off;
    off = int'(t.alu & 32'd3);
    case (t.src)
      2'd0: return t.alu;
      2'd2: return t.pc + 32'd4;
      2'd3: return 32'd0;
      default: ;
    endcase
    if (t.size == 2'd0) begin
      v = (t.dload >> (8 * off)) & 32'hFF;
      if (t.sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (t.size == 2'd1) begin
      v = (t.dload >> (8 * (off & 2))) & 32'hFFFF;
      if (t.sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = t.dload;
    end
    return v;
  endfunction

  function automatic logic exp_mis(txn_t t);
    int off;
    off = int'(t.alu & 32'd3);
    if (t.src != 2'd1) return 1'b0;
    if (t.size == 2'd0) return 1'b0;
    if (t.size == 2'd1) return (off % 2) == 1;
    return off != 0;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t.pc    = $urandom;
    t.alu   = $urandom;
    t.dload = $urandom;
    t.halt  = 1'b0;
    t.rd    = 5'($urandom);
    t.wen   = 1'($urandom);
    t.src   = 2'($urandom);
    t.size  = 2'($urandom);
    t.sgn   = 1'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input logic [31:0] pc,
                              input logic [31:0] alu,
                              input logic [31:0] dl,
                              input logic [1:0] src,
                              input logic [1:0] size,
                              input logic sgn);
    txn_t t;
    t.pc = pc; t.alu = alu; t.dload = dl;
    t.halt = 1'b0; t.rd = 5'd3; t.wen = 1'b1;
    t.src = src; t.size = size; t.sgn = sgn;
    return t;
  endfunction

  task automatic drive(input txn_t t, input logic v);
    bus.in_valid      = v;
    bus.in_pc         = t.pc;
    bus.in_alu_out    = t.alu;
    bus.in_dload      = t.dload;
    bus.in_halt       = t.halt;
    bus.in_rd         = t.rd;
    bus.in_reg_wen    = t.wen;
    bus.in_wr_src     = t.src;
    bus.in_mem_size   = t.size;
    bus.in_mem_signed = t.sgn;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic one(input txn_t t);
    drive(t, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Reference: a two-deep FIFO of raw input transactions.
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      q.delete();
      m_halted = 0;
    end else begin
      txn_t t;
      bit ret, cap;
      t.pc = bus.in_pc; t.alu = bus.in_alu_out;
      t.dload = bus.in_dload; t.halt = bus.in_halt;
      t.rd = bus.in_rd; t.wen = bus.in_reg_wen;
      t.src = bus.in_wr_src; t.size = bus.in_mem_size;
      t.sgn = bus.in_mem_signed;
      ret = q.size() > 0 && bus.out_ready;
      cap = bus.in_valid && q.size() < 2 && !m_halted;
      if (ret && q[0].halt) m_halted = 1;
      if (flush) begin
        q.delete();
      end else begin
        if (ret) void'(q.pop_front());
        if (cap) q.push_back(t);
      end
    end
  end

  always @(negedge clk) begin
    if (nRST) begin
      logic w;
      chk("out_valid", 64'(bus.out_valid),
          64'(q.size() > 0));
      chk("in_ready", 64'(bus.in_ready),
          64'(q.size() < 2 && !m_halted));
      chk("halted", 64'(bus.halted), 64'(m_halted));
      if (q.size() > 0) begin
        w = q[0].wen && (q[0].rd != 5'd0);
        chk("wb_pc", 64'(bus.wb_pc), 64'(q[0].pc));
        chk("wb_rd", 64'(bus.wb_rd), 64'(q[0].rd));
        chk("wb_wen", 64'(bus.wb_wen), 64'(w));
        chk("wb_data", 64'(bus.wb_data),
            64'(exp_data(q[0])));
        chk("wb_misalign", 64'(bus.wb_misalign),
            64'(exp_mis(q[0])));
        chk("fwd_valid", 64'(bus.fwd_valid), 64'(w));
        chk("fwd_rd", 64'(bus.fwd_rd), 64'(q[0].rd));
        chk("fwd_data", 64'(bus.fwd_data),
            64'(exp_data(q[0])));
      end
    end
  end

  initial begin
    txn_t a, b, c, h;
    drive(rnd(), 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    nRST = 1'b1;
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_wb_pc", 64'(bus.wb_pc), 64'd0);

    one(mk(32'h100, 32'h1000_0002, 32'h80FF7F01,
           2'd1, 2'd0, 1'b1));
    chk("lb_off2_s", 64'(bus.wb_data), 64'hFFFF_FFFF);
    one(mk(32'h104, 32'h1000_0002, 32'h80FF7F01,
           2'd1, 2'd0, 1'b0));
    chk("lbu_off2", 64'(bus.wb_data), 64'h0000_00FF);
    one(mk(32'h108, 32'h1000_0001, 32'h80FF7F01,
           2'd1, 2'd0, 1'b1));
    chk("lb_off1_s", 64'(bus.wb_data), 64'h0000_007F);
    one(mk(32'h10C, 32'h1000_0001, 32'h80FF7F01,
           2'd1, 2'd1, 1'b0));
    chk("lh_off1_mis", 64'(bus.wb_misalign), 64'd1);
    chk("lh_off1_data", 64'(bus.wb_data), 64'h0000_7F01);
    one(mk(32'hFFFF_FFFC, 32'h1000_0001, 32'h0,
           2'd2, 2'd0, 1'b0));
    chk("pc4_wrap", 64'(bus.wb_data), 64'd0);
    chk("pc4_no_mis", 64'(bus.wb_misalign), 64'd0);
    c = mk(32'h110, 32'h55, 32'h0, 2'd0, 2'd2, 1'b0);
    c.rd = 5'd0;
    one(c);
    chk("rd0_valid", 64'(bus.out_valid), 64'd1);
    chk("rd0_wen", 64'(bus.wb_wen), 64'd0);
    chk("rd0_fwd", 64'(bus.fwd_valid), 64'd0);
    tick();

    a = mk(32'hA000, 32'h11, 32'h0, 2'd0, 2'd2, 1'b0);
    b = mk(32'hB000, 32'h22, 32'h0, 2'd0, 2'd2, 1'b0);
    bus.out_ready = 1'b0;
    one(a);
    chk("skid_rdy_a", 64'(bus.in_ready), 64'd1);
    drive(b, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("skid_rdy_b", 64'(bus.in_ready), 64'd0);
    chk("skid_hold1", 64'(bus.wb_pc), 64'hA000);
    tick();
    chk("skid_hold2", 64'(bus.wb_pc), 64'hA000);
    chk("skid_hold_d", 64'(bus.wb_data), 64'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("skid_b_head", 64'(bus.wb_pc), 64'hB000);
    chk("skid_b_valid", 64'(bus.out_valid), 64'd1);
    tick();
    chk("skid_empty", 64'(bus.out_valid), 64'd0);

    bus.out_ready = 1'b0;
    one(a);
    drive(b, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    chk("flush_drop", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 2000; i++) begin
      drive(rnd(), ($urandom_range(0, 9) < 7));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 3);
      tick();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    h = mk(32'hC000, 32'h7, 32'h0, 2'd0, 2'd2, 1'b0);
    h.halt = 1'b1;
    one(h);
    chk("halt_head", 64'(bus.out_valid), 64'd1);
    tick();
    chk("halted_set", 64'(bus.halted), 64'd1);
    chk("halted_rdy", 64'(bus.in_ready), 64'd0);
    drive(a, 1'b1);
    repeat (3) begin
      tick();
      chk("halt_ignore", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("halt_flush", 64'(bus.halted), 64'd1);
    nRST = 1'b0;
    #1;
    chk("rst_async_halt", 64'(bus.halted), 64'd0);
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    #20;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
